// File: rtl/bus_master_port.sv
// bus_master_port: serial bus master with arbitration, split transactions and ack timeout
module bus_master_port #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              request,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              error,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              m_dout,
    output logic              m_valid,
    output logic              m_mode,
    input  logic              m_din,
    input  logic              s_valid,
    input  logic              s_ready,
    input  logic              s_split
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, SPLIT, DONE} state_t;
    localparam int CMAX = (ADDR_W > TIMEOUT ? ADDR_W : TIMEOUT) > DATA_W ?
                          (ADDR_W > TIMEOUT ? ADDR_W : TIMEOUT) : DATA_W;
    localparam int CW = $clog2(CMAX + 1);
    localparam int AB = $clog2(ADDR_W);
    localparam int DB = $clog2(DATA_W);
    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, rx, rx_next;
    logic              rd_q, err_q, adv;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // adv marks cycles where the shared bit/wait counter steps; any state change clears it
    always_comb begin
        nxt = state;
        adv = 1'b0;
        case (state)
            IDLE: nxt = enable ? REQ : IDLE;
            REQ: nxt = bus_grant ? ADDR : REQ;
            ADDR: begin
                adv = bus_grant;
                nxt = !bus_grant ? REQ : (cnt == CW'(ADDR_W - 1)) ? WAIT_ACK : ADDR;
            end
            WAIT_ACK: begin
                adv = 1'b1;
                nxt = s_split ? SPLIT : s_ready ? (rd_q ? RDATA : WDATA) :
                      (cnt == CW'(TIMEOUT - 1)) ? DONE : WAIT_ACK;
            end
            WDATA: begin
                adv = bus_grant;
                nxt = !bus_grant ? REQ : (cnt == CW'(DATA_W - 1)) ? DONE : WDATA;
            end
            RDATA: begin
                adv = s_valid;
                nxt = (s_valid && cnt == CW'(DATA_W - 1)) ? DONE : RDATA;
            end
            SPLIT: nxt = (!s_split && bus_grant) ? (rd_q ? RDATA : WDATA) : SPLIT;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        rx_next = rx;
        rx_next[cnt[DB-1:0]] = m_din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            rx       <= '0;
            data_out <= '0;
        end else begin
            cnt <= (nxt != state) ? '0 : cnt + CW'(adv);
            if (state == IDLE && enable) begin
                addr_q <= addr_in;
                data_q <= data_in;
                rd_q   <= read_en;
            end
            if (state == WAIT_ACK) err_q <= (nxt == DONE);
            else if (state == IDLE) err_q <= 1'b0;
            if (state == RDATA && s_valid) rx <= rx_next;
            if (state == RDATA && nxt == DONE) data_out <= rx_next;
        end
    end
    assign request = state != IDLE && state != DONE;
    assign bus_req = request && !(state == SPLIT && s_split);
    assign m_valid = (state == ADDR || state == WDATA) && bus_grant;
    assign m_dout  = m_valid && (state == ADDR ? addr_q[cnt[AB-1:0]] : data_q[cnt[DB-1:0]]);
    assign m_mode  = state != IDLE && !rd_q;
    assign done    = state == DONE;
    assign error   = done && err_q;
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: scoreboard bench for bus_master_port with directed transactions
module tb_bus_master_port;
    logic clk, reset, enable, read_en, request, done, error, bus_req, bus_grant;
    logic m_dout, m_valid, m_mode, m_din, s_valid, s_ready, s_split;
    logic [7:0]  data_in, data_out;
    logic [13:0] addr_in;
    typedef struct packed {logic mode; logic b;} bit_t;
    typedef struct packed {logic err; logic mode; logic [7:0] d;} done_t;
    bit_t  bit_q[$];
    done_t done_q[$];
    bit_t  eb;
    done_t ed;
    int    n_cmp = 0, n_bad = 0, n;

    bus_master_port dut (
        .clk(clk), .reset(reset), .enable(enable), .read_en(read_en),
        .data_in(data_in), .addr_in(addr_in), .request(request), .data_out(data_out),
        .done(done), .error(error), .bus_req(bus_req), .bus_grant(bus_grant),
        .m_dout(m_dout), .m_valid(m_valid), .m_mode(m_mode), .m_din(m_din),
        .s_valid(s_valid), .s_ready(s_ready), .s_split(s_split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen within bound", nm);
    endtask

    // monitor: every serial bit and every completion pulse is checked against the queues
    always @(negedge clk) begin
        if (m_valid) begin
            if (bit_q.size() == 0) miss("unexpected_serial_bit");
            else begin
                eb = bit_q.pop_front();
                chk("serial_bit_mode", 32'({m_mode, m_dout}), 32'(eb));
            end
        end
        if (done) begin
            if (done_q.size() == 0) miss("unexpected_done");
            else begin
                ed = done_q.pop_front();
                chk("done_err_mode_data", 32'({error, m_mode, data_out}), 32'(ed));
            end
        end
    end

    task automatic push_bits(input logic mode, input logic [15:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) bit_q.push_back({mode, v[i]});
    endtask

    task automatic issue(input logic rd, input logic [13:0] a, input logic [7:0] d);
        read_en = rd;
        addr_in = a;
        data_in = d;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) return;
        end
        miss(nm);
    endtask

    task automatic wait_valid(input logic lvl, input string nm);
        for (int i = 0; i < 60; i++) begin
            if (m_valid === lvl) return;
            @(negedge clk);
        end
        miss(nm);
    endtask

    task automatic wait_addr_done(input string nm);
        @(negedge clk);
        wait_valid(1'b1, {nm, "_addr_start"});
        wait_valid(1'b0, {nm, "_addr_end"});
    endtask

    task automatic send_rx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            m_din = v[i];
            @(posedge clk); #1;
            if (i % 3 == 0) begin
                s_valid = 1'b0;
                m_din = ~v[i];
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        m_din = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; read_en = 1'b0; data_in = '0; addr_in = '0;
        bus_grant = 1'b0; m_din = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_split = 1'b0;
        #12;
        chk("reset_outputs", 32'({request, done, error, bus_req, m_dout, m_valid, m_mode, data_out}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // write 0x1555 / 0xAA
        bus_grant = 1'b1; s_ready = 1'b1;
        push_bits(1'b1, 16'h1555, 14);
        push_bits(1'b1, 16'h00AA, 8);
        done_q.push_back({1'b0, 1'b1, 8'h00});
        issue(1'b0, 14'h1555, 8'hAA);
        wait_done("write_done");
        @(posedge clk); #1;

        // read 0x1389 returning 0x55 with s_valid gaps
        push_bits(1'b0, 16'h1389, 14);
        done_q.push_back({1'b0, 1'b0, 8'h55});
        issue(1'b1, 14'h1389, 8'h00);
        wait_addr_done("read");
        @(posedge clk); #1;
        send_rx(8'h55);
        wait_done("read_done");
        @(posedge clk); #1;

        // split read: bus released for 10 cycles, no address resend
        s_ready = 1'b0;
        push_bits(1'b0, 16'h2A7C, 14);
        done_q.push_back({1'b0, 1'b0, 8'hC3});
        issue(1'b1, 14'h2A7C, 8'h00);
        wait_addr_done("split");
        s_split = 1'b1;
        bus_grant = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("split_bus_req_low", 32'(bus_req), 0);
        end
        s_split = 1'b0;
        @(negedge clk);
        chk("split_bus_req_again", 32'({bus_req, request}), 32'b11);
        bus_grant = 1'b1;
        @(posedge clk); #1;
        send_rx(8'hC3);
        wait_done("split_done");
        @(posedge clk); #1;

        // timeout write: no ack, data_out keeps 0xC3
        push_bits(1'b1, 16'h0F0F, 14);
        done_q.push_back({1'b1, 1'b1, 8'hC3});
        issue(1'b0, 14'h0F0F, 8'h3C);
        wait_addr_done("timeout");
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(n), 16);
        @(posedge clk); #1;

        // grant lost at address bit 5, address restarts after regrant
        s_ready = 1'b1;
        push_bits(1'b1, 16'h2B5D, 5);
        push_bits(1'b1, 16'h2B5D, 14);
        push_bits(1'b1, 16'h0096, 8);
        done_q.push_back({1'b0, 1'b1, 8'hC3});
        issue(1'b0, 14'h2B5D, 8'h96);
        @(negedge clk);
        wait_valid(1'b1, "grant_drop_addr_start");
        repeat (5) @(posedge clk);
        #1 bus_grant = 1'b0;
        @(negedge clk);
        chk("grant_drop_valid_req", 32'({m_valid, bus_req}), 32'b01);
        @(posedge clk);
        @(negedge clk);
        chk("grant_drop_hold_req", 32'({bus_req, request, m_valid}), 32'b110);
        @(posedge clk); #1;
        bus_grant = 1'b1;
        wait_done("grant_drop_done");
        @(posedge clk); #1;

        // busy enable ignored, then reset in the middle of write data
        push_bits(1'b1, 16'h0123, 14);
        push_bits(1'b1, 16'h00F0, 3);
        read_en = 1'b0; addr_in = 14'h0123; data_in = 8'hF0; enable = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b1; addr_in = 14'h3FFF; data_in = 8'h0F;
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        wait_addr_done("reset_txn");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("reset_mid_wdata", 32'({request, done, error, bus_req, m_dout, m_valid, m_mode, data_out}), 0);
        @(posedge clk); #1;
        chk("reset_held", 32'({request, done, bus_req, m_valid, m_mode, data_out}), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // first transaction after reset
        push_bits(1'b0, 16'h0001, 14);
        done_q.push_back({1'b0, 1'b0, 8'h81});
        issue(1'b1, 14'h0001, 8'h00);
        wait_addr_done("post_reset");
        @(posedge clk); #1;
        send_rx(8'h81);
        wait_done("post_reset_done");
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        chk("bit_queue_drained", 32'(bit_q.size()), 0);
        chk("done_queue_drained", 32'(done_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_master_port.md
BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 SHALL have parameter ADDR_W, 14, address width (2-bit slave select + 12-bit offset).
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter TIMEOUT, 15, max cycles in WAIT_ACK before error.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  command strobe from controller.
REQ-007 SHALL have port read_en  in  1  1=read, 0=write, sampled with enable.
REQ-008 SHALL have port data_in  in  DATA_W  write data, sampled with enable.
REQ-009 SHALL have port addr_in  in  ADDR_W  target address, sampled with enable.
REQ-010 SHALL have port request  out  1  transaction in progress, visible to controller.
REQ-011 SHALL have port data_out  out  DATA_W  last read data.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port error  out  1  set with done on timeout, else 0.
REQ-014 SHALL have port bus_req  out  1  arbitration request.
REQ-015 SHALL have port bus_grant  in  1  arbitration grant.
REQ-016 SHALL have port m_dout  out  1  serial address/write data, LSB first.
REQ-017 SHALL have port m_valid  out  1  m_dout bit valid this cycle.
REQ-018 SHALL have port m_mode  out  1  1=write, 0=read, held from ADDR to DONE.
REQ-019 SHALL have port m_din  in  1  serial read data, LSB first.
REQ-020 SHALL have port s_valid  in  1  m_din bit valid this cycle.
REQ-021 SHALL have port s_ready  in  1  slave accepts address.
REQ-022 SHALL have port s_split  in  1  slave requests split.

Function
REQ-023 SHALL implement states IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, SPLIT, DONE.
REQ-024 IDLE: on enable=1 SHALL latch addr_in/data_in/read_en, set request=1, bus_req=1, go REQ next cycle.
REQ-025 enable SHALL be ignored in every state except IDLE; latched command unchanged.
REQ-026 REQ: on bus_grant=1 SHALL clear bit counter and go ADDR.
REQ-027 ADDR: SHALL drive m_valid=1, m_dout=addr[bit] for exactly ADDR_W cycles, bits 0..ADDR_W-1, then go WAIT_ACK.
REQ-028 WAIT_ACK: m_valid=0; s_split=1 SHALL go SPLIT (priority over s_ready); s_ready=1 SHALL go WDATA (write) or RDATA (read); wait counter reaching TIMEOUT with neither SHALL go DONE with error=1.
REQ-029 WDATA: SHALL drive m_valid=1, m_dout=data[bit] for exactly DATA_W cycles LSB first, then DONE.
REQ-030 RDATA: SHALL shift m_din into bit position bit-count only on cycles with s_valid=1; after DATA_W valid bits SHALL load data_out and go DONE; cycles without s_valid do not advance.
REQ-031 SPLIT: SHALL drop bus_req to 0 while s_split=1; on s_split=0 SHALL reassert bus_req and on bus_grant=1 go to data phase (WDATA/RDATA) without resending address.
REQ-032 Loss of bus_grant in ADDR or WDATA SHALL abort the phase, hold bus_req=1, return REQ, and restart address from bit 0.
REQ-033 DONE: SHALL pulse done=1 one cycle, drop request and bus_req, go IDLE; error cleared in IDLE.
REQ-034 m_mode SHALL equal ~latched read_en from ADDR through DONE, 0 in IDLE.
REQ-035 Counters SHALL be sized for max(ADDR_W, TIMEOUT) without wrap; data_out unchanged on write or error.

Reset
REQ-036 reset=1 SHALL immediately force IDLE and all outputs to 0 (data_out=0), from any state, with no done pulse.
REQ-037 After reset release the first enable SHALL start a clean transaction.

Verification
REQ-038 Write: enable, read_en=0, addr=0x1555, data=0xAA, grant next cycle, s_ready after address -> m_dout 14 address bits LSB-first, then 0,1,0,1,0,1,0,1; done one cycle; error=0.
REQ-039 Read: addr=0x1389, s_ready, m_din supplies 0x55 with s_valid gaps -> data_out=0x55 at done; m_mode=0 throughout.
REQ-040 Split: read, s_split=1 for 10 cycles after address -> bus_req=0 during split, reasserted after; no address resent; data received; done.
REQ-041 Timeout: no s_ready/s_split for 15 cycles -> done=1 with error=1, data_out unchanged.
REQ-042 Grant drop at address bit 5 -> return REQ, address restarts at bit 0 after regrant.
REQ-043 Reset asserted mid-WDATA, and enable pulsed while busy -> outputs 0 immediately; busy enable has no effect on latched command.
